register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 16 +
 rtl/register_file_decoder.sv | 17 +
 rtl/register_file_mux.sv | 19 +
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the 16 x 32 register file and its decode/read stages.
package register_file_pkg;

    localparam int NUM_REGS   = 16;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_sel_t;

    // True when the addressed register is the hardwired zero register.
    function automatic logic is_zero_target(input logic zero_reg, input reg_addr_t addr);
        return zero_reg && (addr == reg_addr_t'(0));
    endfunction

endpackage

// File: rtl/register_file_decoder.sv
// 4-to-16 one-hot write-enable decoder for the register file.
module decoder_4to16
    import register_file_pkg::*;
(
    input  logic        en,
    input  logic [3:0]  addr,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file_mux.sv
// 16:1 word multiplexer; the sixteen inputs arrive packed, word i at bits [i*Length +: Length].
module mux_16to1 #(
    parameter int Length = 32
) (
    input  logic [16*Length-1:0] din,
    input  logic [3:0]           sel,
    output logic [Length-1:0]    dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < 16; i++) begin
            if (sel == 4'(i)) begin
                dout = din[i*Length +: Length];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// 16-entry register file: one synchronous write port, two combinational read ports.
// Optional write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module register_file
    import register_file_pkg::*;
#(
    parameter int Length   = DATA_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              we,
    input  logic [3:0]        wr_addr,
    input  logic [Length-1:0] wr_data,
    input  logic [3:0]        rd_addr0,
    input  logic [3:0]        rd_addr1,
    output logic [Length-1:0] rd_data0,
    output logic [Length-1:0] rd_data1
);

    logic [Length-1:0]          regs [NUM_REGS];
    reg_sel_t                   wr_onehot_raw;
    reg_sel_t                   wr_onehot;
    logic [NUM_REGS*Length-1:0] rd_bus;
    logic [Length-1:0]          rd_mux0;
    logic [Length-1:0]          rd_mux1;

    decoder_4to16 u_wr_dec (
        .en     (we),
        .addr   (wr_addr),
        .onehot (wr_onehot_raw)
    );

    always_comb begin
        wr_onehot = wr_onehot_raw;
        if (ZERO_REG) begin
            wr_onehot[0] = 1'b0;
        end
    end

    // Reset clears the whole array and takes priority over a same-edge write.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_onehot[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_bus = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_bus[i*Length +: Length] = regs[i];
        end
        if (ZERO_REG) begin
            rd_bus[0 +: Length] = '0;
        end
    end

    mux_16to1 #(.Length(Length)) u_rd_mux0 (
        .din  (rd_bus),
        .sel  (rd_addr0),
        .dout (rd_mux0)
    );

    mux_16to1 #(.Length(Length)) u_rd_mux1 (
        .din  (rd_bus),
        .sel  (rd_addr1),
        .dout (rd_mux1)
    );

`ifdef REGFILE_BYPASS_EN
    logic fwd0;
    logic fwd1;

    // Forward only a write that will actually land: not during reset, never into r0 when hardwired.
    always_comb begin
        fwd0 = we && rstb && (wr_addr == rd_addr0) && !is_zero_target(ZERO_REG, wr_addr);
        fwd1 = we && rstb && (wr_addr == rd_addr1) && !is_zero_target(ZERO_REG, wr_addr);
    end

    assign rd_data0 = fwd0 ? wr_data : rd_mux0;
    assign rd_data1 = fwd1 ? wr_data : rd_mux1;
`else
    assign rd_data0 = rd_mux0;
    assign rd_data1 = rd_mux1;
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file; drives a ZERO_REG=1 and a ZERO_REG=0 instance in parallel.
module tb_register_file;

    logic        clk;
    logic        rstb;
    logic        we;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr0;
    logic [3:0]  rd_addr1;
    logic [31:0] rz0, rz1, rn0, rn1;

    int checks;
    int failures;

    logic [31:0] mz [16];
    logic [31:0] mn [16];

    register_file #(.Length(32), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rstb(rstb), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rz0), .rd_data1(rz1)
    );

    register_file #(.Length(32), .ZERO_REG(1'b0)) dut_n (
        .clk(clk), .rstb(rstb), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rn0), .rd_data1(rn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference: register array semantics straight from the rules (reset clears, r0 hardwired when zr).
    function automatic logic [31:0] exp_rd(input bit zr, input logic [3:0] a);
        logic [31:0] v;
        v = zr ? ((a == 4'd0) ? 32'h0 : mz[a]) : mn[a];
`ifdef REGFILE_BYPASS_EN
        if (we && rstb && wr_addr == a && !(zr && a == 4'd0)) v = wr_data;
`endif
        return v;
    endfunction

    task automatic step();
        if (!rstb) begin
            for (int i = 0; i < 16; i++) begin
                mz[i] = 32'h0;
                mn[i] = 32'h0;
            end
        end else if (we) begin
            if (wr_addr != 4'd0) mz[wr_addr] = wr_data;
            mn[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0; we = 1'b1; wr_addr = 4'd4; wr_data = $urandom;
        step();
        step();
        rstb = 1'b1; we = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr0 = 4'(a); rd_addr1 = 4'(15 - a);
            #2;
            checks += 4;
            if (rz0 !== 32'h0) begin failures++; $display("FAIL reset_z0 addr=%0d got=%h exp=0", a, rz0); end
            if (rz1 !== 32'h0) begin failures++; $display("FAIL reset_z1 addr=%0d got=%h exp=0", 15 - a, rz1); end
            if (rn0 !== 32'h0) begin failures++; $display("FAIL reset_n0 addr=%0d got=%h exp=0", a, rn0); end
            if (rn1 !== 32'h0) begin failures++; $display("FAIL reset_n1 addr=%0d got=%h exp=0", 15 - a, rn1); end
        end
    endtask

    task automatic test_write_readback();
        for (int i = 1; i < 16; i++) do_write(4'(i), 32'hA5A5_0000 + 32'(i));
        for (int a = 0; a < 16; a++) begin
            logic [31:0] e;
            rd_addr0 = 4'(a); rd_addr1 = 4'(a);
            e = (a == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(a);
            #2;
            checks += 4;
            if (rz0 !== e) begin failures++; $display("FAIL readback_z0 addr=%0d got=%h exp=%h", a, rz0, e); end
            if (rz1 !== e) begin failures++; $display("FAIL readback_z1 addr=%0d got=%h exp=%h", a, rz1, e); end
            if (rn0 !== e) begin failures++; $display("FAIL readback_n0 addr=%0d got=%h exp=%h", a, rn0, e); end
            if (rn1 !== e) begin failures++; $display("FAIL readback_n1 addr=%0d got=%h exp=%h", a, rn1, e); end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] e;
        rd_addr0 = 4'd0; rd_addr1 = 4'd0;
        we = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF;
        #2;
        e = exp_rd(1'b0, 4'd0);
        checks += 2;
        if (rz0 !== 32'h0) begin failures++; $display("FAIL zero_same_cycle_z got=%h exp=0", rz0); end
        if (rn0 !== e) begin failures++; $display("FAIL zero_same_cycle_n got=%h exp=%h", rn0, e); end
        step();
        we = 1'b0;
        #2;
        checks += 3;
        if (rz0 !== 32'h0) begin failures++; $display("FAIL zero_after_z got=%h exp=0", rz0); end
        if (rz1 !== 32'h0) begin failures++; $display("FAIL zero_after_z1 got=%h exp=0", rz1); end
        if (rn0 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL zero_after_n got=%h exp=ffffffff", rn0); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] e;
        do_write(4'd5, 32'h1111_1111);
        rd_addr0 = 4'd5; rd_addr1 = 4'd6;
        we = 1'b1; wr_addr = 4'd5; wr_data = 32'h2222_2222;
        #2;
`ifdef REGFILE_BYPASS_EN
        e = 32'h2222_2222;
`else
        e = 32'h1111_1111;
`endif
        checks += 3;
        if (rz0 !== e) begin failures++; $display("FAIL same_cycle_z got=%h exp=%h", rz0, e); end
        if (rn0 !== e) begin failures++; $display("FAIL same_cycle_n got=%h exp=%h", rn0, e); end
        if (rz1 !== 32'hA5A5_0006) begin failures++; $display("FAIL same_cycle_other got=%h exp=a5a50006", rz1); end
        step();
        we = 1'b0;
        #2;
        checks += 2;
        if (rz0 !== 32'h2222_2222) begin failures++; $display("FAIL next_cycle_z got=%h exp=22222222", rz0); end
        if (rn0 !== 32'h2222_2222) begin failures++; $display("FAIL next_cycle_n got=%h exp=22222222", rn0); end
    endtask

    task automatic test_reset_beats_write();
        do_write(4'd3, 32'hDEAD_BEEF);
        rd_addr0 = 4'd3; rd_addr1 = 4'd3;
        rstb = 1'b0; we = 1'b1; wr_addr = 4'd3; wr_data = 32'h1234_5678;
        #2;
        checks += 1;
        if (rz0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL no_fwd_in_reset got=%h exp=deadbeef", rz0); end
        step();
        rstb = 1'b1; we = 1'b0;
        #2;
        checks += 4;
        if (rz0 !== 32'h0) begin failures++; $display("FAIL reset_wins_z0 got=%h exp=0", rz0); end
        if (rz1 !== 32'h0) begin failures++; $display("FAIL reset_wins_z1 got=%h exp=0", rz1); end
        if (rn0 !== 32'h0) begin failures++; $display("FAIL reset_wins_n0 got=%h exp=0", rn0); end
        rd_addr1 = 4'd5;
        #1;
        if (rn1 !== 32'h0) begin failures++; $display("FAIL reset_clears_all got=%h exp=0", rn1); end
    endtask

    task automatic test_dual_port();
        do_write(4'd7, 32'h7);
        do_write(4'd9, 32'h9);
        rd_addr0 = 4'd7; rd_addr1 = 4'd9;
        we = 1'b0; wr_addr = 4'($urandom); wr_data = $urandom;
        #2;
        checks += 4;
        if (rz0 !== 32'h7) begin failures++; $display("FAIL dual_z0 got=%h exp=7", rz0); end
        if (rz1 !== 32'h9) begin failures++; $display("FAIL dual_z1 got=%h exp=9", rz1); end
        if (rn0 !== 32'h7) begin failures++; $display("FAIL dual_n0 got=%h exp=7", rn0); end
        if (rn1 !== 32'h9) begin failures++; $display("FAIL dual_n1 got=%h exp=9", rn1); end
        step();
        for (int a = 0; a < 16; a++) begin
            logic [31:0] ez, en;
            rd_addr0 = 4'(a); rd_addr1 = 4'(a);
            #1;
            ez = exp_rd(1'b1, 4'(a));
            en = exp_rd(1'b0, 4'(a));
            checks += 2;
            if (rz0 !== ez) begin failures++; $display("FAIL we0_unchanged_z addr=%0d got=%h exp=%h", a, rz0, ez); end
            if (rn1 !== en) begin failures++; $display("FAIL we0_unchanged_n addr=%0d got=%h exp=%h", a, rn1, en); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] e0z, e1z, e0n, e1n;
            rstb     = ($urandom_range(0, 24) != 0);
            we       = $urandom_range(0, 2) != 0;
            wr_addr  = 4'($urandom);
            wr_data  = $urandom;
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
            rd_addr1 = 4'($urandom);
            #2;
            e0z = exp_rd(1'b1, rd_addr0); e1z = exp_rd(1'b1, rd_addr1);
            e0n = exp_rd(1'b0, rd_addr0); e1n = exp_rd(1'b0, rd_addr1);
            checks += 4;
            if (rz0 !== e0z) begin failures++; $display("FAIL rand_z0 n=%0d addr=%0d got=%h exp=%h", n, rd_addr0, rz0, e0z); end
            if (rz1 !== e1z) begin failures++; $display("FAIL rand_z1 n=%0d addr=%0d got=%h exp=%h", n, rd_addr1, rz1, e1z); end
            if (rn0 !== e0n) begin failures++; $display("FAIL rand_n0 n=%0d addr=%0d got=%h exp=%h", n, rd_addr0, rn0, e0n); end
            if (rn1 !== e1n) begin failures++; $display("FAIL rand_n1 n=%0d addr=%0d got=%h exp=%h", n, rd_addr1, rn1, e1n); end
            step();
        end
        rstb = 1'b1; we = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rstb = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
        for (int i = 0; i < 16; i++) begin
            mz[i] = 32'h0;
            mn[i] = 32'h0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_write_readback();
        test_zero_reg();
        test_same_cycle();
        test_reset_beats_write();
        test_dual_port();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
